pwm_multi_gen: RTL and testbench
================================

PWM_MULTI_GEN -- requirements
Module: pwm_multi_gen

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of PWM channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the period counter, period register and duty registers.
REQ-003 The block SHALL have parameter PRESC, default 1, giving the number of clk cycles per counter tick (PRESC >= 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-005 The block SHALL have port arstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: run enable.
REQ-007 The block SHALL have port cfg_we, input, 1 bit: configuration write strobe, one write per cycle.
REQ-008 The block SHALL have port cfg_addr, input, $clog2(N_CH+2) bits: register address.
REQ-009 The block SHALL have port cfg_wdata, input, CNT_W bits: write data.
REQ-010 The block SHALL have port pwm_o, output, N_CH bits: registered PWM outputs.
REQ-011 The block SHALL have port period_end, output, 1 bit: registered one-cycle pulse at each period wrap.

Function
REQ-012 The register map SHALL be:
- addr 0: TOP (period).
- addr 1..N_CH: DUTY[addr-1].
- addr N_CH+1: POL, a polarity mask in bits [N_CH-1:0]; upper bits are ignored.
- Any other address: the write is ignored.
REQ-013 A write SHALL update only the shadow copy of the addressed register on the clk edge where cfg_we=1.
REQ-014 A tick SHALL occur every PRESC clk cycles while en=1; the prescaler SHALL be cleared while en=0.
REQ-015 On each tick the counter SHALL step 0,1,...,TOP_active and then wrap to 0, giving a period of (TOP_active+1) ticks.
REQ-016 On a tick where cnt==TOP_active, the block SHALL:
- Load all shadow registers into the active registers.
- Assert period_end on the next clk edge for exactly one clk cycle.
REQ-017 A shadow write on the same clk edge as a wrap load SHALL NOT be included in that load; it SHALL take effect at the following wrap.
REQ-018 While en=0, the block SHALL:
- Hold cnt at 0.
- Copy shadow registers into active registers every cycle.
- Drive pwm_o to all-zero and period_end to 0.
REQ-019 While en=1, each cycle the block SHALL register pwm_o[i] = (cnt < DUTY_active[i]) XOR POL_active[i], so pwm_o lags cnt by one clk.
REQ-020 The compare SHALL be unsigned over CNT_W bits, with the following boundary cases:
- DUTY=0 gives constant low (before polarity).
- DUTY > TOP_active gives constant high (before polarity).
REQ-021 With TOP_active=0, the counter SHALL remain at 0 and period_end SHALL pulse on every tick.
REQ-022 The counter SHALL never exceed TOP_active; if TOP is lowered, the new value SHALL apply only from the next wrap.
REQ-023 On the first tick after en rises, counting SHALL start from cnt=0 using the active registers loaded while en was low.

Reset
REQ-024 While arstn=0, the block SHALL immediately and asynchronously clear the following to 0:
- cnt and the prescaler.
- All shadow and active TOP, DUTY and POL registers.
- pwm_o and period_end.
REQ-025 A reset asserted mid-period SHALL discard any pending shadow values.
REQ-026 After arstn deasserts, the block SHALL require a full reconfiguration before producing non-zero output.

Verification (N_CH=4, CNT_W=8, PRESC=1 unless stated)
REQ-027 The bench SHALL cover:
- Reset mid-run: with en=1 and TOP=9 running, drop arstn -> pwm_o=0000 and period_end=0 with no clk edge; after release and en=1 without writes -> pwm_o stays 0000.
- Basic: write TOP=9 and DUTY0=3, then en=1 -> pwm_o[0] high 3 clk and low 7 clk repeating; period_end pulses every 10 clk.
- Extremes: TOP=9, DUTY1=0, DUTY2=10 -> pwm_o[1] constant 0 and pwm_o[2] constant 1 across 3 periods.
- Shadow update: DUTY3=2 running; write DUTY3=7 mid-period -> current period keeps width 2; first period after period_end has width 7.
- Polarity and boundary write: POL=0100 and DUTY2=4 -> pwm_o[2] low 4 and high 6; a write of TOP=4 on the wrap edge takes effect one period later.
- Prescaler (PRESC=3) and TOP=0: period_end pulses every 3 clk; DUTY0=1 -> pwm_o[0] constant 1.

Source files
------------

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: N_CH-channel PWM with a shared period counter, shadowed
// TOP/DUTY/POL registers loaded at each period wrap, and a clk prescaler.
module pwm_multi_gen #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int PRESC = 1
) (
  input  logic                        clk,
  input  logic                        arstn,
  input  logic                        en,
  input  logic                        cfg_we,
  input  logic [$clog2(N_CH+2)-1:0]   cfg_addr,
  input  logic [CNT_W-1:0]            cfg_wdata,
  output logic [N_CH-1:0]             pwm_o,
  output logic                        period_end
);
  localparam int AW = $clog2(N_CH + 2);
  localparam int PW = PRESC > 1 ? $clog2(PRESC) : 1;
  logic [PW-1:0]    psc;
  logic [CNT_W-1:0] cnt, top_s, top_a;
  logic [CNT_W-1:0] duty_s [N_CH];
  logic [CNT_W-1:0] duty_a [N_CH];
  logic [N_CH-1:0]  pol_s, pol_a, cmp;
  logic             tick, wrap;
  assign tick = en && psc == PW'(PRESC - 1);
  assign wrap = tick && cnt == top_a;
  for (genvar i = 0; i < N_CH; i++) begin : g_cmp
    assign cmp[i] = (cnt < duty_a[i]) ^ pol_a[i];
  end
  // Active registers track the shadows while idle so enabling starts clean.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      psc        <= '0;
      cnt        <= '0;
      top_s      <= '0;
      top_a      <= '0;
      pol_s      <= '0;
      pol_a      <= '0;
      pwm_o      <= '0;
      period_end <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        duty_s[i] <= '0;
        duty_a[i] <= '0;
      end
    end else begin
      psc <= (!en || tick) ? '0 : psc + PW'(1);
      cnt <= (!en || wrap) ? '0 : tick ? cnt + CNT_W'(1) : cnt;
      if (cfg_we && cfg_addr == '0) top_s <= cfg_wdata;
      if (cfg_we && cfg_addr == AW'(N_CH + 1)) pol_s <= cfg_wdata[N_CH-1:0];
      for (int i = 0; i < N_CH; i++)
        if (cfg_we && cfg_addr == AW'(i + 1)) duty_s[i] <= cfg_wdata;
      if (!en || wrap) begin
        top_a  <= top_s;
        pol_a  <= pol_s;
        duty_a <= duty_s;
      end
      pwm_o      <= en ? cmp : '0;
      period_end <= wrap;
    end
  end
endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb_pwm_multi_gen: directed checks of pwm_multi_gen (PRESC=1 and PRESC=3
// instances sharing one configuration stream).
module tb_pwm_multi_gen;
  logic       clk = 1'b0;
  logic       arstn, en, cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [3:0] pwm1, pwm3;
  logic       pe1, pe3;
  int         n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  pwm_multi_gen #(.N_CH(4), .CNT_W(8), .PRESC(1)) u_dut (
    .clk(clk), .arstn(arstn), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .pwm_o(pwm1), .period_end(pe1));

  pwm_multi_gen #(.N_CH(4), .CNT_W(8), .PRESC(3)) u_dut3 (
    .clk(clk), .arstn(arstn), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .pwm_o(pwm3), .period_end(pe3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] ev;
    logic       ep;
    int         c;
    arstn = 1'b0; en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    #3;
    check("reset pwm", pwm1, 0);
    check("reset pe", pe1, 0);
    check("reset pwm3", pwm3, 0);
    @(negedge clk) arstn = 1'b1;
    step();
    // basic: TOP=9 DUTY0=3
    wr(0, 9);
    wr(1, 3);
    step();
    check("idle pwm", pwm1, 0);
    en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      c = (k - 1) % 10;
      ev = {3'b000, c < 3};
      check($sformatf("basic pwm k=%0d", k), pwm1, ev);
      check($sformatf("basic pe k=%0d", k), pe1, k % 10 == 0);
    end
    // extremes + shadow update of DUTY3 mid-period
    en = 1'b0;
    step();
    wr(2, 0);
    wr(3, 10);
    wr(4, 2);
    step();
    check("en0 pwm", pwm1, 0);
    check("en0 pe", pe1, 0);
    en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin
        cfg_we = 1'b1; cfg_addr = 3'd4; cfg_wdata = 8'd7;
      end else cfg_we = 1'b0;
      step();
      c = (k - 1) % 10;
      ev = {(k <= 10) ? c < 2 : c < 7, 1'b1, 1'b0, c < 3};
      check($sformatf("ext pwm k=%0d", k), pwm1, ev);
      check($sformatf("ext pe k=%0d", k), pe1, k % 10 == 0);
    end
    cfg_we = 1'b0;
    // reset mid-run: outputs clear without a clock edge
    step(); step(); step();
    #2 arstn = 1'b0;
    #1;
    check("async rst pwm", pwm1, 0);
    check("async rst pe", pe1, 0);
    @(negedge clk) arstn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("post rst pwm k=%0d", k), pwm1, 0);
      check($sformatf("post rst pe k=%0d", k), pe1, 1);
    end
    // polarity + TOP write on the wrap edge
    en = 1'b0;
    step();
    wr(0, 9);
    wr(1, 3);
    wr(3, 4);
    wr(4, 7);
    wr(5, 8'h04);
    wr(6, 8'hff);
    step();
    en = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      if (k == 10) begin
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 8'd4;
      end else cfg_we = 1'b0;
      step();
      c  = (k <= 20) ? (k - 1) % 10 : (k - 21) % 5;
      ep = (k <= 20) ? k % 10 == 0 : (k - 20) % 5 == 0;
      ev = {c < 7, !(c < 4), 1'b0, c < 3};
      check($sformatf("pol pwm k=%0d", k), pwm1, ev);
      check($sformatf("pol pe k=%0d", k), pe1, ep);
    end
    cfg_we = 1'b0;
    // TOP=0 with both prescaler settings
    en = 1'b0;
    step();
    wr(0, 0);
    wr(1, 1);
    wr(5, 0);
    step();
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("top0 pwm k=%0d", k), pwm1, 4'b1101);
      check($sformatf("top0 pe k=%0d", k), pe1, 1);
      check($sformatf("presc pwm k=%0d", k), pwm3, 4'b1101);
      check($sformatf("presc pe k=%0d", k), pe3, k % 3 == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
